// File: rtl/pea_pkg.sv
// rtl/pea_pkg.sv - shared types and constants for the streaming PE array
package pea_pkg;

    localparam int PEA_CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } s_ctrl_state_t;

endpackage

// File: rtl/s_stream_cnt.sv
// rtl/s_stream_cnt.sv - clearable, enable-gated up-counter with terminal-count flag
module s_stream_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

    // Asserted while the next increment would reach the limit.
    assign last_o = (limit_i != '0) && (cnt_o == limit_i - 1'b1);

endmodule

// File: rtl/s_pea_stream_ctrl.sv
// rtl/s_pea_stream_ctrl.sv - kernel sequencer driving the global PEA advance and done signals
module s_pea_stream_ctrl
    import pea_pkg::*;
#(
    parameter int N_IN_STREAMS  = 4,
    parameter int N_OUT_STREAMS = 4,
    parameter int CNT_W         = PEA_CNT_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [CNT_W-1:0]         n_inputs_i,
    input  logic [CNT_W-1:0]         n_outputs_i,
    input  logic [15:0]              acc_len_i,
    input  logic [N_IN_STREAMS-1:0]  in_mask_i,
    input  logic [N_OUT_STREAMS-1:0] out_mask_i,
    input  logic [N_IN_STREAMS-1:0]  in_valid_i,
    output logic [N_IN_STREAMS-1:0]  in_ready_o,
    input  logic [N_OUT_STREAMS-1:0] pe_valid_i,
    output logic [N_OUT_STREAMS-1:0] out_valid_o,
    input  logic [N_OUT_STREAMS-1:0] out_ready_i,
    output logic                     pea_ready_o,
    output logic [15:0]              reg_acc_value_o,
    output logic                     mage_done_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         out_count_o
);

    s_ctrl_state_t state_q, state_d;

    logic [CNT_W-1:0]         n_in_q, n_out_q;
    logic [15:0]              acc_q;
    logic [N_IN_STREAMS-1:0]  in_mask_q;
    logic [N_OUT_STREAMS-1:0] out_mask_q;

    logic             cfg_load, in_en, out_en;
    logic             in_last, out_last, in_exhausted;
    logic             in_ok, out_ok, out_all;
    logic [CNT_W-1:0] in_cnt, out_cnt;

    assign in_ok   = &(in_valid_i | ~in_mask_q);
    assign out_ok  = &(out_ready_i | ~out_mask_q);
    assign out_all = ((pe_valid_i & out_mask_q) == out_mask_q);
    // Also true on the first RUN cycle of a kernel with zero inputs.
    assign in_exhausted = (in_cnt == n_in_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            n_in_q     <= '0;
            n_out_q    <= '0;
            acc_q      <= '0;
            in_mask_q  <= '0;
            out_mask_q <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_load) begin
                n_in_q     <= n_inputs_i;
                n_out_q    <= n_outputs_i;
                acc_q      <= acc_len_i;
                in_mask_q  <= in_mask_i;
                out_mask_q <= out_mask_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pea_ready_o = 1'b0;
        in_ready_o  = '0;
        out_valid_o = '0;
        mage_done_o = 1'b0;
        cfg_load    = 1'b0;
        in_en       = 1'b0;
        out_en      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cfg_load = 1'b1;
                    state_d  = (n_outputs_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (abort_i) begin
                    state_d = S_DONE;
                end else begin
                    if ((state_q == S_RUN) && !in_exhausted) begin
                        pea_ready_o = in_ok & out_ok;
                        in_en       = pea_ready_o;
                        in_ready_o  = pea_ready_o ? in_mask_q : '0;
                        if (in_en && in_last) state_d = S_DRAIN;
                    end else begin
                        pea_ready_o = out_ok;
                        state_d     = S_DRAIN;
                    end
                    out_valid_o = pea_ready_o ? (pe_valid_i & out_mask_q) : '0;
                    out_en      = pea_ready_o & out_all;
                    // Output completion wins over any inputs still pending.
                    if (out_en && out_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                mage_done_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    s_stream_cnt #(.W(CNT_W)) u_in_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cfg_load),
        .en_i    (in_en),
        .limit_i (n_in_q),
        .cnt_o   (in_cnt),
        .last_o  (in_last)
    );

    s_stream_cnt #(.W(CNT_W)) u_out_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cfg_load),
        .en_i    (out_en),
        .limit_i (n_out_q),
        .cnt_o   (out_cnt),
        .last_o  (out_last)
    );

    assign busy_o          = (state_q != S_IDLE);
    assign out_count_o     = out_cnt;
    assign reg_acc_value_o = acc_q;

endmodule

// File: doc/s_pea_stream_ctrl.md
Name: s_pea_stream_ctrl

Overview:
- Sequences one streaming kernel on the streaming Processing Element Array.
- Latches the kernel configuration on start and generates the global pea_ready/mage_done pair seen by every s_pe.
- Gates input-stream consumption and output-stream production with per-stream masks.
- Counts consumed inputs and produced outputs; terminates the kernel with a one-cycle done pulse that clears PE state.

Parameters:
- N_IN_STREAMS, 4, number of input stream ports feeding the PEA.
- N_OUT_STREAMS, 4, number of PE result taps driven to output streams.
- CNT_W, 16, width of the input/output sample counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  kernel start pulse; ignored unless IDLE
- abort_i  in  1  terminate the kernel immediately
- n_inputs_i  in  CNT_W  input samples per enabled stream; latched on start
- n_outputs_i  in  CNT_W  output samples per enabled stream; latched on start
- acc_len_i  in  16  accumulation length; latched on start
- in_mask_i  in  N_IN_STREAMS  enabled input streams; latched on start
- out_mask_i  in  N_OUT_STREAMS  enabled output streams; latched on start
- in_valid_i  in  N_IN_STREAMS  input stream valid
- in_ready_o  out  N_IN_STREAMS  input stream ready
- pe_valid_i  in  N_OUT_STREAMS  valid_o of the tapped PEs
- out_valid_o  out  N_OUT_STREAMS  output stream valid
- out_ready_i  in  N_OUT_STREAMS  output stream ready
- pea_ready_o  out  1  global advance enable to all PEs
- reg_acc_value_o  out  16  latched acc_len, to all PEs
- mage_done_o  out  1  one-cycle kernel-end pulse to all PEs
- busy_o  out  1  high in every state except IDLE
- out_count_o  out  CNT_W  outputs produced so far

Behaviour:
- Reset: state=IDLE; all counters, latched config and outputs are 0. Reset mid-kernel drops to IDLE with no done pulse.
- Derived terms:
  - in_ok = &(in_valid_i | ~in_mask_q)
  - out_ok = &(out_ready_i | ~out_mask_q)
  - out_all = ((pe_valid_i & out_mask_q) == out_mask_q)
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i latches the configuration, clears both counters and moves to RUN.
  - If the latched n_outputs is 0, go directly to DONE instead.
  - start_i while busy is ignored.
- RUN:
  - pea_ready_o = in_ok & out_ok (combinational).
  - in_ready_o = in_mask_q when pea_ready_o, else 0.
  - in_cnt increments when pea_ready_o=1.
  - When in_cnt reaches n_inputs_q-1 and increments, go to DRAIN.
  - If n_inputs_q=0, the first RUN cycle goes to DRAIN with no input accepted.
- DRAIN:
  - pea_ready_o = out_ok; in_ready_o = 0.
- Output handshake (RUN and DRAIN only):
  - out_valid_o = pe_valid_i & out_mask_q when pea_ready_o, else 0.
  - out_cnt increments when pea_ready_o & out_all.
  - When out_cnt reaches n_outputs_q, go to DONE. This applies from RUN or DRAIN; any remaining inputs are left unconsumed.
  - out_count_o = out_cnt.
- DONE:
  - mage_done_o=1 for exactly one cycle; pea_ready_o=0; then go to IDLE.
- abort_i:
  - In RUN or DRAIN, go to DONE next cycle. No handshake completes in the abort cycle (pea_ready_o forced 0).
  - In IDLE or DONE, abort_i is ignored.
  - A simultaneous start_i and abort_i in IDLE performs the start.
- Counter width: counters saturate-compare at CNT_W bits; the maximum count is 2^CNT_W-1.
- Combinational paths: pea_ready_o depends combinationally on in_valid_i and out_ready_i; no ready-to-valid loop is permitted.
- reg_acc_value_o: holds the latched value until the next start.
- Latency: start to first possible pea_ready_o is 1 cycle. Last output handshake to mage_done_o is 1 cycle.

Decomposition:
- Add to pea_pkg:
  - s_ctrl_state_t enum {S_IDLE, S_RUN, S_DRAIN, S_DONE}
  - default CNT_W constant
- One sub-module, s_stream_cnt: a loadable, enable-gated up-counter with a terminal-count flag, instantiated twice (input and output).
- Mask reduction and FSM stay in the top module.

Test Plan:
- Basic kernel: n_inputs=4, n_outputs=4, in_mask=0001, out_mask=0001, all valid/ready high, pe_valid high from the 2nd RUN cycle.
  - pea_ready_o high 5 cycles; 4 in_ready pulses.
  - out_count_o reaches 4, then mage_done_o pulses once; busy_o falls the next cycle.
- Input stall: in_mask=0011 with in_valid_i[1] low for cycles 2-4.
  - pea_ready_o=0 and in_ready_o=00 during the stall.
  - in_cnt and out_cnt frozen; the kernel completes 3 cycles later than the basic case.
- Backpressure in DRAIN: n_inputs=2, n_outputs=4, out_ready_i low 2 cycles in DRAIN.
  - pea_ready_o=0 and out_valid_o=0 while low; no count increment; done follows the 4th output.
- Zero outputs: start with n_outputs=0.
  - Next cycle DONE with mage_done_o=1; pea_ready_o never asserted.
- Abort: abort_i at out_count_o=2 of 8.
  - pea_ready_o=0 that cycle; mage_done_o pulses the next cycle; out_count_o stays 2.
  - start_i during the kernel has no effect.
- Reset mid-RUN: rst_i=1 for one cycle.
  - All outputs 0; state IDLE; no mage_done_o pulse; acc_len reloads correctly on the next start (e.g. 16 → reg_acc_value_o=16).
